// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: walks data registers 0..n_tx_end through an SPI mode-0 master.
// Optional macro SPI_XFER_LOOPBACK_EN: capture MOSI in place of MISO.
module spi_xfer_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9,
   parameter int DIV    = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              send_i,
   input  logic              all_ones_i,
   input  logic              all_zeros_i,
   input  logic [ADDR_W-1:0] n_tx_end_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              miso_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [ADDR_W-1:0] n_rx_o,
   output logic              wr_en_o,
   output logic              wr_sel_o,
   output logic              busy_o,
   output logic              cs_o,
   output logic              sclk_o,
   output logic              mosi_o
);

   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      STORE,
      NEXT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [ADDR_W-1:0] n_rx_q, n_rx_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DCW-1:0]    div_q, div_d;
   logic [BCW-1:0]    bit_q, bit_d;
   logic              wr_en_q, wr_en_d;
   logic              wr_sel_q, wr_sel_d;
   logic              busy_q, busy_d;
   logic              cs_q, cs_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;

   logic              rx_bit;
   logic [DATA_W-1:0] tx_word;

`ifdef SPI_XFER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso_i;
   assign rx_bit = mosi_q;
`else
   assign rx_bit = miso_i;
`endif

   // Word source for the next transfer; forced patterns override register data
   always_comb begin
      tx_word = rdata_i;
      if (all_ones_i) begin
         tx_word = '1;
      end else if (all_zeros_i) begin
         tx_word = '0;
      end
   end

   // Next-state and next-output logic for the sequencer and shifter
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      end_d    = end_q;
      n_rx_d   = n_rx_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      wdata_d  = wdata_q;
      div_d    = div_q;
      bit_d    = bit_q;
      wr_en_d  = 1'b0;
      wr_sel_d = 1'b0;
      busy_d   = busy_q;
      cs_d     = cs_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      unique case (state_q)
         IDLE: begin
            if (send_i) begin
               state_d = LOAD;
               end_d   = n_tx_end_i;
               addr_d  = '0;
               busy_d  = 1'b1;
               cs_d    = 1'b0;
            end
         end
         LOAD: begin
            tx_d    = tx_word;
            mosi_d  = tx_word[DATA_W-1];
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_d = {rx_q[DATA_W-2:0], rx_bit};
               end else begin
                  tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                  mosi_d = tx_q[DATA_W-2];
                  bit_d  = bit_q + BCW'(1);
                  if (bit_q == BIT_LAST) begin
                     state_d = STORE;
                  end
               end
            end else begin
               div_d = div_q + DCW'(1);
            end
         end
         STORE: begin
            wr_en_d  = 1'b1;
            wr_sel_d = 1'b1;
            wdata_d  = rx_q;
            state_d  = NEXT;
         end
         NEXT: begin
            if (addr_q == end_q) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = LOAD;
            end
         end
         DONE: begin
            wr_en_d = 1'b1;
            n_rx_d  = addr_q;
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous reset aborts any transfer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         end_q    <= '0;
         n_rx_q   <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         wdata_q  <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         wr_en_q  <= 1'b0;
         wr_sel_q <= 1'b0;
         busy_q   <= 1'b0;
         cs_q     <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         end_q    <= end_d;
         n_rx_q   <= n_rx_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         wdata_q  <= wdata_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         wr_en_q  <= wr_en_d;
         wr_sel_q <= wr_sel_d;
         busy_q   <= busy_d;
         cs_q     <= cs_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

   assign addr_o   = addr_q;
   assign wdata_o  = wdata_q;
   assign n_rx_o   = n_rx_q;
   assign wr_en_o  = wr_en_q;
   assign wr_sel_o = wr_sel_q;
   assign busy_o   = busy_q;
   assign cs_o     = cs_q;
   assign sclk_o   = sclk_q;
   assign mosi_o   = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: vector table, hand sequences and random transfers
// against a word-level model of the bank walk.
module tb_spi_xfer_ctrl;

   localparam int DW = 8;
   localparam int AW = 9;
   localparam int DV = 2;
   localparam int NW = 512;
   localparam int WCYC = 2 * DV * DW;

   typedef struct {
      int         n_end;
      bit         ao;
      bit         az;
      logic [7:0] rdata;
      logic [7:0] miso;
      logic [7:0] exp_mosi;
      logic [7:0] exp_wd;
   } vec_t;

   typedef struct {
      logic          sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [AW-1:0] n_rx;
   } wr_t;

   logic          clk;
   logic          rst_i;
   logic          send_i;
   logic          all_ones_i;
   logic          all_zeros_i;
   logic [AW-1:0] n_tx_end_i;
   logic [DW-1:0] rdata_i;
   logic          miso_i;
   logic [AW-1:0] addr_o;
   logic [DW-1:0] wdata_o;
   logic [AW-1:0] n_rx_o;
   logic          wr_en_o;
   logic          wr_sel_o;
   logic          busy_o;
   logic          cs_o;
   logic          sclk_o;
   logic          mosi_o;

   logic [DW-1:0] mem [NW];
   logic [DW-1:0] slave_words [NW];
   wr_t           wr_log [$];
   logic          mosi_bits [$];
   logic [15:0]   nfall;
   logic          sclk_prev;
   int            sel_viol;
   int            cs_viol;
   int            n_pass;
   int            n_total;

   spi_xfer_ctrl #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .DIV   (DV)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .send_i     (send_i),
      .all_ones_i (all_ones_i),
      .all_zeros_i(all_zeros_i),
      .n_tx_end_i (n_tx_end_i),
      .rdata_i    (rdata_i),
      .miso_i     (miso_i),
      .addr_o     (addr_o),
      .wdata_o    (wdata_o),
      .n_rx_o     (n_rx_o),
      .wr_en_o    (wr_en_o),
      .wr_sel_o   (wr_sel_o),
      .busy_o     (busy_o),
      .cs_o       (cs_o),
      .sclk_o     (sclk_o),
      .mosi_o     (mosi_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rdata_i = mem[addr_o];
   assign miso_i  = slave_words[nfall[11:3]][~nfall[2:0]];

   // Mode-0 slave and bus monitor, sampled on the inactive clock edge
   always @(negedge clk) begin
      if (cs_o) begin
         nfall <= '0;
      end else if (sclk_prev && !sclk_o) begin
         nfall <= nfall + 16'd1;
      end
      if (!cs_o && !sclk_prev && sclk_o) begin
         mosi_bits.push_back(mosi_o);
      end
      sclk_prev <= sclk_o;
      if (wr_en_o) begin
         wr_log.push_back('{wr_sel_o, addr_o, wdata_o, n_rx_o});
      end
      if (!wr_en_o && wr_sel_o) begin
         sel_viol <= sel_viol + 1;
      end
      if (busy_o && cs_o) begin
         cs_viol <= cs_viol + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mosi_word(input int k);
      logic [7:0] w;
      w = '0;
      for (int j = 0; j < 8; j++) begin
         w = {w[6:0], mosi_bits[8 * k + j]};
      end
      return w;
   endfunction

   task automatic run_xfer(input int n_end, input bit ao, input bit az);
      int cyc;
      wr_log.delete();
      mosi_bits.delete();
      n_tx_end_i  = AW'(n_end);
      all_ones_i  = ao;
      all_zeros_i = az;
      send_i      = 1'b1;
      tick();
      send_i = 1'b0;
      cyc = 0;
      while (busy_o && cyc < (n_end + 1) * (WCYC + 3) + 20) begin
         tick();
         cyc++;
      end
      check("xfer_done", {31'd0, busy_o}, 32'd0);
      tick();
   endtask

   // Word-level expectation: every index 0..n_end read, sent, and written back
   task automatic verify(input int n_end, input bit ao, input bit az);
      logic [7:0] exp_tx;
      logic [7:0] exp_wd;
      check("mosi_len", mosi_bits.size(), 8 * (n_end + 1));
      check("wr_count", wr_log.size(), n_end + 2);
      for (int k = 0; k <= n_end; k++) begin
         exp_tx = ao ? 8'hFF : (az ? 8'h00 : mem[k]);
`ifdef SPI_XFER_LOOPBACK_EN
         exp_wd = exp_tx;
`else
         exp_wd = slave_words[k];
`endif
         if (8 * k + 7 < mosi_bits.size()) begin
            check("mosi_word", mosi_word(k), exp_tx);
         end
         if (k < wr_log.size()) begin
            check("data_sel", wr_log[k].sel, 1);
            check("data_addr", wr_log[k].addr, k);
            check("data_wdata", wr_log[k].wd, exp_wd);
         end
      end
      if (wr_log.size() == n_end + 2) begin
         check("ctrl_sel", wr_log[n_end+1].sel, 0);
         check("ctrl_n_rx", wr_log[n_end+1].n_rx, n_end);
      end
   endtask

   task automatic fill(input logic [7:0] rd, input logic [7:0] mi);
      for (int i = 0; i < NW; i++) begin
         mem[i]         = rd;
         slave_words[i] = mi;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < NW; i++) begin
         mem[i]         = 8'($urandom);
         slave_words[i] = 8'($urandom);
      end
   endtask

   vec_t vecs [5];

   initial begin
      int cyc;
      int n_end;
      bit ao;
      bit az;
      n_pass      = 0;
      n_total     = 0;
      sel_viol    = 0;
      cs_viol     = 0;
      nfall       = '0;
      sclk_prev   = 1'b0;
      rst_i       = 1'b1;
      send_i      = 1'b0;
      all_ones_i  = 1'b0;
      all_zeros_i = 1'b0;
      n_tx_end_i  = '0;
      fill(8'h00, 8'h00);

`ifdef SPI_XFER_LOOPBACK_EN
      vecs[0] = '{0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'hA5};
      vecs[1] = '{2, 1'b1, 1'b0, 8'h00, 8'h81, 8'hFF, 8'hFF};
      vecs[2] = '{0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{1, 1'b0, 1'b0, 8'h5A, 8'h00, 8'h5A, 8'h5A};
`else
      vecs[0] = '{0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{2, 1'b1, 1'b0, 8'h00, 8'h81, 8'hFF, 8'h81};
      vecs[2] = '{0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{1, 1'b0, 1'b0, 8'h5A, 8'h00, 8'h5A, 8'h00};
`endif

      tick();
      tick();
      check("rst_addr", addr_o, 0);
      check("rst_wdata", wdata_o, 0);
      check("rst_n_rx", n_rx_o, 0);
      check("rst_ctl", {wr_en_o, wr_sel_o, busy_o, cs_o, sclk_o, mosi_o},
            6'b000100);
      rst_i = 1'b0;
      tick();
      tick();

      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_rst_hold", {cs_o, sclk_o, wr_en_o}, 3'b100);
      end
      rst_i = 1'b0;
      tick();

      // Single word cycle-by-cycle: load, 32 shift cycles, store, done
      fill(8'hA5, 8'h3C);
      wr_log.delete();
      mosi_bits.delete();
      n_tx_end_i = '0;
      send_i     = 1'b1;
      tick();
      send_i = 1'b0;
      check("start_busy_cs", {busy_o, cs_o, addr_o}, {2'b10, 9'd0});
      cyc = 0;
      while (!wr_en_o && cyc < 200) begin
         tick();
         cyc++;
      end
      check("store_latency", cyc, WCYC + 2);
      check("store_sel_addr", {wr_sel_o, addr_o}, {1'b1, 9'd0});
`ifdef SPI_XFER_LOOPBACK_EN
      check("store_wdata", wdata_o, 8'hA5);
`else
      check("store_wdata", wdata_o, 8'h3C);
`endif
      tick();
      check("next_gap", {wr_en_o, busy_o}, 2'b01);
      tick();
      check("done_write", {wr_en_o, wr_sel_o, busy_o, cs_o}, 4'b1001);
      check("done_n_rx", n_rx_o, 0);
      check("single_mosi", mosi_word(0), 8'hA5);
      tick();
      check("after_done", {wr_en_o, busy_o}, 2'b00);

      for (int v = 0; v < 5; v++) begin
         fill(vecs[v].rdata, vecs[v].miso);
         run_xfer(vecs[v].n_end, vecs[v].ao, vecs[v].az);
         if (mosi_bits.size() >= 8) begin
            check("tbl_mosi", mosi_word(0), vecs[v].exp_mosi);
         end
         if (wr_log.size() > 0) begin
            check("tbl_wdata", wr_log[0].wd, vecs[v].exp_wd);
         end
         verify(vecs[v].n_end, vecs[v].ao, vecs[v].az);
      end

      // Reset during SHIFT after the 4th rising SCLK edge
      fill(8'hA5, 8'h3C);
      wr_log.delete();
      mosi_bits.delete();
      n_tx_end_i = AW'(3);
      send_i     = 1'b1;
      tick();
      send_i = 1'b0;
      cyc = 0;
      while (mosi_bits.size() < 4 && cyc < 100) begin
         tick();
         cyc++;
      end
      check("abort_reach_4", mosi_bits.size(), 4);
      rst_i = 1'b1;
      tick();
      check("abort_state", {cs_o, sclk_o, busy_o, wr_en_o}, 4'b1000);
      rst_i = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
      end
      check("abort_no_write", wr_log.size(), 0);

      for (int r = 0; r < 10; r++) begin
         fill_rand();
         n_end = $urandom_range(0, 5);
         ao    = ($urandom_range(0, 3) == 0);
         az    = ($urandom_range(0, 3) == 0);
         run_xfer(n_end, ao, az);
         verify(n_end, ao, az);
      end

      fill_rand();
      run_xfer(NW - 1, 1'b0, 1'b0);
      verify(NW - 1, 1'b0, 1'b0);

      check("sel_without_en", sel_viol, 0);
      check("cs_high_while_busy", cs_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
